// File: rtl/scaler_dsp_top.sv
// Separable 4x4 polyphase scaler tap: vertical Q0.8 filter per column, then horizontal Q0.8 filter.
// Fixed 6-cycle latency, one result per cycle; no backpressure, so outputs must be taken when valid.
module scaler_dsp_top (
  input  logic         core_clk,
  input  logic         core_rst,
  input  logic         s_axis_scaler_valid,
  input  logic [127:0] s_axis_scaler_pixel,
  input  logic [31:0]  s_axis_scaler_coef_h,
  input  logic [31:0]  s_axis_scaler_coef_v,
  input  logic         s_axis_scaler_done,
  output logic         m_axis_core_valid,
  output logic [7:0]   m_axis_core_data,
  output logic         m_axis_core_done
);

  localparam int LAT = 6;

  // Bit i of each control pipe lines up with datapath stage i.
  logic [LAT:0] vld_pipe;
  logic [LAT:0] done_pipe;

  logic [7:0]  pix0 [4][4];
  logic [7:0]  cv0  [4];
  logic [7:0]  ch0  [4];
  logic [7:0]  ch1  [4];
  logic [7:0]  ch2  [4];
  logic [7:0]  ch3  [4];
  logic [15:0] pv1  [4][4];
  logic [17:0] sv2  [4];
  logic [7:0]  v3   [4];
  logic [15:0] ph4  [4];
  logic [17:0] sh5;
  logic [7:0]  data6;

  function automatic logic [15:0] mul8(input logic [7:0] a, input logic [7:0] b);
    return {8'd0, a} * {8'd0, b};
  endfunction

  function automatic logic [17:0] sum4(input logic [15:0] a, input logic [15:0] b,
                                       input logic [15:0] c, input logic [15:0] d);
    return 18'(a) + 18'(b) + 18'(c) + 18'(d);
  endfunction

  // Round half up from Q.8 and clamp; 4*255*255+128 still fits in 18 bits.
  function automatic logic [7:0] round_sat(input logic [17:0] s);
    logic [17:0] t;
    t = s + 18'd128;
    return (|t[17:16]) ? 8'hff : t[15:8];
  endfunction

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      vld_pipe  <= '0;
      done_pipe <= '0;
      data6     <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[LAT-1:0], s_axis_scaler_valid};
      done_pipe <= {done_pipe[LAT-1:0], s_axis_scaler_done};
      if (vld_pipe[LAT-1]) begin
        data6 <= round_sat(sh5);
      end
    end
  end

  // Datapath carries no reset; only the control pipes decide what is visible.
  always_ff @(posedge core_clk) begin
    for (int r = 0; r < 4; r++) begin
      cv0[r] <= s_axis_scaler_coef_v[8*r +: 8];
      ch0[r] <= s_axis_scaler_coef_h[8*r +: 8];
      for (int c = 0; c < 4; c++) begin
        pix0[r][c] <= s_axis_scaler_pixel[8*(4*r+c) +: 8];
        pv1[r][c]  <= mul8(cv0[r], pix0[r][c]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      ch1[c] <= ch0[c];
      ch2[c] <= ch1[c];
      ch3[c] <= ch2[c];
      sv2[c] <= sum4(pv1[0][c], pv1[1][c], pv1[2][c], pv1[3][c]);
      v3[c]  <= round_sat(sv2[c]);
      ph4[c] <= mul8(ch3[c], v3[c]);
    end
    sh5 <= sum4(ph4[0], ph4[1], ph4[2], ph4[3]);
  end

  assign m_axis_core_valid = vld_pipe[LAT];
  assign m_axis_core_done  = done_pipe[LAT];
  assign m_axis_core_data  = data6;

endmodule

// File: tb/tb_scaler_dsp_top.sv
// Vector table plus streaming and reset sequences, checked through an expected-output queue.
module tb_scaler_dsp_top;

  logic         core_clk = 1'b0;
  logic         core_rst;
  logic         s_axis_scaler_valid;
  logic [127:0] s_axis_scaler_pixel;
  logic [31:0]  s_axis_scaler_coef_h;
  logic [31:0]  s_axis_scaler_coef_v;
  logic         s_axis_scaler_done;
  logic         m_axis_core_valid;
  logic [7:0]   m_axis_core_data;
  logic         m_axis_core_done;

  scaler_dsp_top dut (
    .core_clk             (core_clk),
    .core_rst             (core_rst),
    .s_axis_scaler_valid  (s_axis_scaler_valid),
    .s_axis_scaler_pixel  (s_axis_scaler_pixel),
    .s_axis_scaler_coef_h (s_axis_scaler_coef_h),
    .s_axis_scaler_coef_v (s_axis_scaler_coef_v),
    .s_axis_scaler_done   (s_axis_scaler_done),
    .m_axis_core_valid    (m_axis_core_valid),
    .m_axis_core_data     (m_axis_core_data),
    .m_axis_core_done     (m_axis_core_done)
  );

  always #5 core_clk = ~core_clk;

  typedef struct {
    logic [127:0] pix;
    logic [31:0]  ch;
    logic [31:0]  cv;
    logic         done;
    logic [7:0]   exp;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   outs  = 0;
  bit   mon_en = 1'b0;
  exp_t sb[$];
  bit   done_exp [0:4095];

  always @(posedge core_clk) cyc <= cyc + 1;

  function automatic logic [7:0] ref_pix(input logic [127:0] p, input logic [31:0] h,
                                         input logic [31:0] v);
    int sv, vc, sh, d;
    sh = 0;
    for (int c = 0; c < 4; c++) begin
      sv = 0;
      for (int r = 0; r < 4; r++)
        sv += int'(v[8*r +: 8]) * int'(p[8*(4*r+c) +: 8]);
      vc = (sv + 128) / 256;
      if (vc > 255) vc = 255;
      sh += int'(h[8*c +: 8]) * vc;
    end
    d = (sh + 128) / 256;
    if (d > 255) d = 255;
    return 8'(d);
  endfunction

  // Inputs change 1 time unit after the falling edge, so the monitor always runs first.
  task automatic drive(input logic v, input logic [127:0] p, input logic [31:0] h,
                       input logic [31:0] cv, input logic d, input logic r, input logic [7:0] e);
    exp_t x;
    @(negedge core_clk);
    #1;
    core_rst             = r;
    s_axis_scaler_valid  = v;
    s_axis_scaler_pixel  = p;
    s_axis_scaler_coef_h = h;
    s_axis_scaler_coef_v = cv;
    s_axis_scaler_done   = d;
    if (r) begin
      sb.delete();
      for (int i = cyc + 1; i < 4096; i++) done_exp[i] = 1'b0;
    end else begin
      if (v) begin
        x.data = e;
        x.due  = cyc + 7;
        sb.push_back(x);
      end
      if (d) done_exp[cyc + 7] = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge core_clk) begin : monitor
    logic exp_v;
    if (mon_en) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        tests++;
        fails++;
        $display("FAIL missed_output: no valid at cycle %0d expected %0d", sb[0].due, sb[0].data);
        void'(sb.pop_front());
      end
      exp_v = (sb.size() > 0 && sb[0].due == cyc);
      check("valid", {7'd0, m_axis_core_valid}, {7'd0, exp_v});
      check("done", {7'd0, m_axis_core_done}, {7'd0, done_exp[cyc]});
      if (exp_v) begin
        check("data", m_axis_core_data, sb[0].data);
        void'(sb.pop_front());
        outs++;
      end
    end
  end

  vec_t          vecs [6];
  logic [127:0]  pix;
  logic [31:0]   sch;
  logic [31:0]   scv;
  int            outs0;

  initial begin
    vecs[0] = '{pix: {16{8'd100}}, ch: 32'h0000_8080, cv: 32'h0000_8080, done: 1'b0, exp: 8'd100};
    vecs[1] = '{pix: {16{8'd255}}, ch: 32'hFFFF_FFFF, cv: 32'hFFFF_FFFF, done: 1'b1, exp: 8'd255};
    vecs[2] = '{pix: 128'd200 << 72, ch: 32'h0000_FF00, cv: 32'h00FF_0000, done: 1'b0, exp: 8'd198};
    vecs[3] = '{pix: {$urandom, $urandom, $urandom, $urandom}, ch: 32'd0, cv: 32'd0, done: 1'b0, exp: 8'd0};
    vecs[4] = '{pix: {16{8'd10}}, ch: 32'h4040_4040, cv: 32'h4040_4040, done: 1'b0, exp: 8'd10};
    vecs[5] = '{pix: {16{8'd255}}, ch: 32'hFF00_0000, cv: 32'h0000_00FF, done: 1'b1, exp: 8'd253};
    for (int i = 0; i < 4096; i++) done_exp[i] = 1'b0;

    // Reset asserted with valid and done high: nothing may get through.
    core_rst             = 1'b1;
    s_axis_scaler_valid  = 1'b1;
    s_axis_scaler_pixel  = {16{8'd50}};
    s_axis_scaler_coef_h = 32'h0000_8080;
    s_axis_scaler_coef_v = 32'h0000_8080;
    s_axis_scaler_done   = 1'b1;
    repeat (3) @(negedge core_clk);
    check("rst_valid", {7'd0, m_axis_core_valid}, 8'd0);
    check("rst_data", m_axis_core_data, 8'd0);
    check("rst_done", {7'd0, m_axis_core_done}, 8'd0);
    mon_en = 1'b1;
    drive(1'b1, {16{8'd50}}, 32'h0000_8080, 32'h0000_8080, 1'b1, 1'b1, 8'd0);

    // Table vectors, first back-to-back then isolated.
    for (int i = 0; i < 6; i++)
      drive(1'b1, vecs[i].pix, vecs[i].ch, vecs[i].cv, vecs[i].done, 1'b0, vecs[i].exp);
    idle(3);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vecs[i].pix, vecs[i].ch, vecs[i].cv, vecs[i].done, 1'b0, vecs[i].exp);
      idle(i + 1);
    end
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0, 8'd0);
    idle(9);

    // 300-cycle stream with ramped pixels and a done pulse in the middle.
    sch = {8'd16, 8'd120, 8'd90, 8'd30};
    scv = {8'd36, 8'd100, 8'd80, 8'd40};
    outs0 = outs;
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 16; k++) pix[8*k +: 8] = 8'((i * 3 + k * 7) & 255);
      drive(1'b1, pix, sch, scv, (i == 150), 1'b0, ref_pix(pix, sch, scv));
    end
    idle(9);
    tests++;
    if (outs - outs0 != 300) begin
      fails++;
      $display("FAIL stream_count: got %0d outputs expected 300", outs - outs0);
    end

    // Reset mid-stream: three in-flight samples (one with done) must vanish.
    drive(1'b1, {16{8'd77}}, 32'h0000_8080, 32'h0000_8080, 1'b0, 1'b0, 8'd77);
    drive(1'b1, {16{8'd78}}, 32'h0000_8080, 32'h0000_8080, 1'b1, 1'b0, 8'd78);
    drive(1'b1, {16{8'd79}}, 32'h0000_8080, 32'h0000_8080, 1'b0, 1'b0, 8'd79);
    drive(1'b1, {16{8'd80}}, 32'h0000_8080, 32'h0000_8080, 1'b1, 1'b1, 8'd0);
    @(negedge core_clk);
    #2;
    check("post_rst_data", m_axis_core_data, 8'd0);
    check("post_rst_valid", {7'd0, m_axis_core_valid}, 8'd0);
    idle(9);

    // Recovery: first sample after reset emerges on time.
    drive(1'b1, vecs[2].pix, vecs[2].ch, vecs[2].cv, 1'b1, 1'b0, vecs[2].exp);
    idle(10);

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected outputs never appeared", sb.size());
    end
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
